// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared definitions for the multi-cycle CPU control path:
//               opcodes, FSM state encoding, instruction classes, ALUOp and
//               PCSrc codes, and the bundle of per-opcode static controls.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Nine states do not fit in three bits, so the state register (and the
    // debug state port) is four bits wide.
    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_AL   = 3'd1,
        CLS_BR   = 3'd2,
        CLS_LS   = 3'd3,
        CLS_JMP  = 3'd4,
        CLS_HALT = 3'd5
    } iclass_t;

    // ALUOp codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // PCSrc codes
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    // Controls that depend only on the opcode
    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_b;
        logic       ext_sel;
        logic       reg_dst;
        logic       db_data_src;
    } static_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Combinational opcode decoder. Produces the instruction class
//               used by the sequencer plus the opcode-only static controls.
// Ports       : i_op     - 6-bit opcode
//               o_iclass - instruction class (AL/BR/LS/JMP/HALT/NOP)
//               o_ctrl   - ALUOp, ALUSrcB, ExtSel, RegDst, DBDataSrc
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   i_op,
    output iclass_t      o_iclass,
    output static_ctrl_t o_ctrl
);

    always_comb begin
        o_iclass       = CLS_NOP;
        o_ctrl         = '0;
        // Sign extension is the common case; only ori zero-extends.
        o_ctrl.ext_sel = 1'b1;
        case (i_op)
            OP_ADD: begin
                o_iclass       = CLS_AL;
                o_ctrl.alu_op  = ALU_ADD;
                o_ctrl.reg_dst = 1'b1;
            end
            OP_SUB: begin
                o_iclass       = CLS_AL;
                o_ctrl.alu_op  = ALU_SUB;
                o_ctrl.reg_dst = 1'b1;
            end
            OP_AND: begin
                o_iclass       = CLS_AL;
                o_ctrl.alu_op  = ALU_AND;
                o_ctrl.reg_dst = 1'b1;
            end
            OP_SLT: begin
                o_iclass       = CLS_AL;
                o_ctrl.alu_op  = ALU_SLT;
                o_ctrl.reg_dst = 1'b1;
            end
            OP_ADDIU: begin
                o_iclass         = CLS_AL;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.alu_src_b = 1'b1;
            end
            OP_ORI: begin
                o_iclass         = CLS_AL;
                o_ctrl.alu_op    = ALU_OR;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.ext_sel   = 1'b0;
            end
            OP_SW: begin
                o_iclass         = CLS_LS;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.alu_src_b = 1'b1;
            end
            OP_LW: begin
                o_iclass           = CLS_LS;
                o_ctrl.alu_op      = ALU_ADD;
                o_ctrl.alu_src_b   = 1'b1;
                o_ctrl.db_data_src = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_iclass      = CLS_BR;
                o_ctrl.alu_op = ALU_SUB;
            end
            OP_J, OP_JR: o_iclass = CLS_JMP;
            OP_HALT:     o_iclass = CLS_HALT;
            default:     o_iclass = CLS_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_ctrl
// Description : Multi-cycle CPU control unit. Sequences each instruction
//               through IF/ID/EXE/MEM/WB and generates the datapath strobes.
//               PCWre pulses once, on the last cycle of each instruction.
// Ports       : CLK, Reset (async, active-high), op, zero (inputs)
//               PCWre, IRWre, RegWre, mRD, mWR, PCSrc, ALUOp, ALUSrcB,
//               ExtSel, RegDst, DBDataSrc, state (outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic       RegDst,
    output logic       DBDataSrc,
    output logic [3:0] state
);

    state_t       r_state_q;
    state_t       w_state_d;
    // Cleared asynchronously by Reset and set on the first edge after it
    // releases: holds every output low until that edge, so a write strobe
    // drops the instant Reset asserts and IRWre does not appear before the
    // clock has seen Reset gone.
    logic         r_run_q;
    iclass_t      w_iclass;
    static_ctrl_t w_ctrl;
    logic         w_br_taken;

    mc_decode u_decode (
        .i_op     (op),
        .o_iclass (w_iclass),
        .o_ctrl   (w_ctrl)
    );

    assign w_br_taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
    assign state      = r_state_q;

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        if (r_run_q) begin
            case (r_state_q)
                S_IF: w_state_d = S_ID;
                S_ID: begin
                    case (w_iclass)
                        CLS_JMP, CLS_NOP: w_state_d = S_IF;
                        CLS_HALT:         w_state_d = S_HALT;
                        CLS_BR:           w_state_d = S_EXE_BR;
                        CLS_LS:           w_state_d = S_EXE_LS;
                        default:          w_state_d = S_EXE_AL;
                    endcase
                end
                S_EXE_AL: w_state_d = S_WB_AL;
                S_EXE_BR: w_state_d = S_IF;
                S_EXE_LS: w_state_d = S_MEM;
                S_MEM:    w_state_d = (op == OP_LW) ? S_WB_LD : S_IF;
                S_WB_AL:  w_state_d = S_IF;
                S_WB_LD:  w_state_d = S_IF;
                S_HALT:   w_state_d = S_HALT;
                default:  w_state_d = S_IF;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state_q <= S_IF;
            r_run_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_run_q   <= 1'b1;
        end
    end

    // Strobes: combinational from state and op
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = PCSRC_SEQ;
        ALUOp     = 3'b000;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        RegDst    = 1'b0;
        DBDataSrc = 1'b0;
        if (r_run_q) begin
            // Static controls are held from ID onward; IF leaves them at 0.
            if (r_state_q != S_IF) begin
                ALUOp     = w_ctrl.alu_op;
                ALUSrcB   = w_ctrl.alu_src_b;
                ExtSel    = w_ctrl.ext_sel;
                RegDst    = w_ctrl.reg_dst;
                DBDataSrc = w_ctrl.db_data_src;
            end
            case (r_state_q)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (w_iclass == CLS_JMP || w_iclass == CLS_NOP) begin
                        PCWre = 1'b1;
                    end
                    if (op == OP_J) begin
                        PCSrc = PCSRC_J;
                    end else if (op == OP_JR) begin
                        PCSrc = PCSRC_JR;
                    end
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    PCSrc = w_br_taken ? PCSRC_BR : PCSRC_SEQ;
                end
                S_MEM: begin
                    if (op == OP_LW) begin
                        mRD = 1'b1;
                    end else if (op == OP_SW) begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end
                end
                S_WB_AL, S_WB_LD: begin
                    RegWre = 1'b1;
                    PCWre  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_ctrl
// Description : Self-checking bench for multi_cycle_ctrl. Each scenario pushes
//               the expected per-cycle output vector onto a scoreboard queue
//               and pops one entry per cycle against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;
    import mc_ctrl_pkg::*;

    logic       CLK   = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] op    = OP_ADD;
    logic       zero  = 1'b0;
    logic       PCWre, IRWre, RegWre, mRD, mWR;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic       ALUSrcB, ExtSel, RegDst, DBDataSrc;
    logic [3:0] state;

    // {state, PCWre, IRWre, RegWre, mRD, mWR, PCSrc, ALUOp, ALUSrcB, ExtSel, RegDst, DBDataSrc}
    logic [17:0] obs;
    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    multi_cycle_ctrl dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .op        (op),
        .zero      (zero),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .RegWre    (RegWre),
        .mRD       (mRD),
        .mWR       (mWR),
        .PCSrc     (PCSrc),
        .ALUOp     (ALUOp),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .RegDst    (RegDst),
        .DBDataSrc (DBDataSrc),
        .state     (state)
    );

    assign obs = {state, PCWre, IRWre, RegWre, mRD, mWR, PCSrc,
                  ALUOp, ALUSrcB, ExtSel, RegDst, DBDataSrc};

    always #5 CLK = ~CLK;

    // {ALUOp, ALUSrcB, ExtSel, RegDst, DBDataSrc} from the opcode table
    function automatic logic [6:0] exp_static(input logic [5:0] o);
        case (o)
            OP_ADD:         return 7'b000_0_1_1_0;
            OP_SUB:         return 7'b001_0_1_1_0;
            OP_AND:         return 7'b010_0_1_1_0;
            OP_SLT:         return 7'b100_0_1_1_0;
            OP_ADDIU:       return 7'b000_1_1_0_0;
            OP_ORI:         return 7'b011_1_0_0_0;
            OP_SW:          return 7'b000_1_1_0_0;
            OP_LW:          return 7'b000_1_1_0_1;
            OP_BEQ, OP_BNE: return 7'b001_0_1_0_0;
            default:        return 7'b000_0_1_0_0;
        endcase
    endfunction

    function automatic logic [17:0] mk(input logic [3:0] st, input logic pcw,
                                       input logic irw, input logic rw,
                                       input logic rd, input logic wr,
                                       input logic [1:0] src, input logic [6:0] sc);
        return {st, pcw, irw, rw, rd, wr, src, sc};
    endfunction

    // Expected per-cycle vectors of one complete instruction, starting at IF
    task automatic push_instr(input logic [5:0] o, input logic z);
        logic [6:0] s;
        s = exp_static(o);
        exp_q.push_back(mk(S_IF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 7'd0));
        case (o)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ORI, OP_SLT: begin
                exp_q.push_back(mk(S_ID,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
                exp_q.push_back(mk(S_EXE_AL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
                exp_q.push_back(mk(S_WB_AL,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, s));
            end
            OP_LW: begin
                exp_q.push_back(mk(S_ID,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
                exp_q.push_back(mk(S_EXE_LS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
                exp_q.push_back(mk(S_MEM,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, s));
                exp_q.push_back(mk(S_WB_LD,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, s));
            end
            OP_SW: begin
                exp_q.push_back(mk(S_ID,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
                exp_q.push_back(mk(S_EXE_LS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
                exp_q.push_back(mk(S_MEM,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, s));
            end
            OP_BEQ, OP_BNE: begin
                exp_q.push_back(mk(S_ID,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
                exp_q.push_back(mk(S_EXE_BR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                   ((o == OP_BEQ) == z) ? 2'b01 : 2'b00, s));
            end
            OP_J:    exp_q.push_back(mk(S_ID, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, s));
            OP_JR:   exp_q.push_back(mk(S_ID, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, s));
            default: exp_q.push_back(mk(S_ID, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
        endcase
    endtask

    // Pops one expected vector per cycle; called and returns at a negedge
    task automatic run_queue(input string name, output int pulses);
        logic [17:0] e;
        int          cyc;
        cyc    = 0;
        pulses = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, e);
            end
            if (PCWre === 1'b1) pulses++;
            cyc++;
            @(negedge CLK);
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] o, input logic z);
        int p;
        op   = o;
        zero = z;
        push_instr(o, z);
        run_queue(name, p);
        n_checks++;
        if (p != 1) begin
            n_fail++;
            $display("FAIL %s pcwre_pulses: got %0d expected 1", name, p);
        end
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (obs !== mk(S_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'd0)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, obs,
                     mk(S_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'd0));
        end
    endtask

    // Called at a negedge with Reset high; returns at the negedge of the first IF
    task automatic release_reset();
        Reset = 1'b0;
        #1;
        check_idle("release_before_edge");
        @(negedge CLK);
    endtask

    task automatic test_reset();
        op = OP_ADD;
        #2 Reset = 1'b1;
        #1 check_idle("reset_async");
        repeat (2) begin
            @(negedge CLK);
            check_idle("reset_held");
        end
        release_reset();
    endtask

    task automatic test_add();
        run_instr("add", OP_ADD, 1'b0);
    endtask

    task automatic test_lw();
        run_instr("lw", OP_LW, 1'b0);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", OP_BEQ, 1'b1);
        run_instr("beq_not_taken", OP_BEQ, 1'b0);
    endtask

    task automatic test_jump();
        run_instr("j", OP_J, 1'b0);
        run_instr("jr", OP_JR, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[10];
        logic       zs[10];
        ops = '{OP_SUB, OP_ADDIU, OP_AND, OP_ORI, OP_SLT, OP_BNE, OP_BNE,
                6'b000011, OP_SW, OP_LW};
        zs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            run_instr($sformatf("b2b_%0d_op%b", i, ops[i]), ops[i], zs[i]);
        end
    endtask

    task automatic test_halt();
        int p;
        logic [6:0] s;
        op = OP_HALT;
        s  = exp_static(OP_HALT);
        exp_q.push_back(mk(S_IF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 7'd0));
        exp_q.push_back(mk(S_ID, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
        repeat (10) exp_q.push_back(mk(S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
        run_queue("halt", p);
        n_checks++;
        if (p != 0) begin
            n_fail++;
            $display("FAIL halt pcwre_pulses: got %0d expected 0", p);
        end
        Reset = 1'b1;
        #1 check_idle("halt_reset");
        @(negedge CLK);
        release_reset();
    endtask

    task automatic test_sw_reset();
        int p;
        logic [6:0] s;
        op = OP_SW;
        s  = exp_static(OP_SW);
        exp_q.push_back(mk(S_IF,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 7'd0));
        exp_q.push_back(mk(S_ID,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
        exp_q.push_back(mk(S_EXE_LS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, s));
        run_queue("sw_reset_pre", p);
        n_checks++;
        if (obs !== mk(S_MEM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, s)) begin
            n_fail++;
            $display("FAIL sw_reset_mem: got %h expected %h", obs,
                     mk(S_MEM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, s));
        end
        Reset = 1'b1;
        #1 check_idle("sw_reset_abort");
        @(negedge CLK);
        check_idle("sw_reset_held");
        release_reset();
        run_instr("after_reset_add", OP_ADD, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_beq();
        test_jump();
        test_back_to_back();
        test_halt();
        test_sw_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
